// File: rtl/sa_ws_stream.sv
// Weight-stationary SIZE x SIZE systolic array with internal operand skew / result de-skew.
// Define SA_SIGNED_EN for two's-complement operands; default build is unsigned.

module sa_ws_dly #(
   parameter int W = 8,
   parameter int D = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   logic [D-1:0][W-1:0] sr_q, sr_d;

   always_comb begin
      sr_d    = sr_q;
      sr_d[0] = d;
      for (int i = 1; i < D; i++) sr_d[i] = sr_q[i-1];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) sr_q <= '0;
      else     sr_q <= sr_d;
   end

   assign q = sr_q[D-1];
endmodule

module sa_ws_pe #(
   parameter int DW    = 8,
   parameter int ACC_W = 20
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [DW-1:0]    w,
   input  logic [DW-1:0]    x_in,
   input  logic [ACC_W-1:0] psum_in,
   output logic [ACC_W-1:0] psum_out
);
   logic [ACC_W-1:0] xe, we, psum_d, psum_q;

   // Extending both operands to ACC_W keeps the low ACC_W product bits exact for either signedness.
   always_comb begin
`ifdef SA_SIGNED_EN
      xe = ACC_W'($signed(x_in));
      we = ACC_W'($signed(w));
`else
      xe = ACC_W'(x_in);
      we = ACC_W'(w);
`endif
      psum_d = psum_in + xe * we;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) psum_q <= '0;
      else     psum_q <= psum_d;
   end

   assign psum_out = psum_q;
endmodule

module sa_ws_stream #(
   parameter int SIZE  = 16,
   parameter int DW    = 8,
   parameter int ACC_W = 20
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  w_start,
   input  logic                  w_valid,
   output logic                  w_ready,
   input  logic [SIZE*DW-1:0]    w_data,
   input  logic                  x_valid,
   output logic                  x_ready,
   input  logic [SIZE*DW-1:0]    x_data,
   output logic                  y_valid,
   output logic [SIZE*ACC_W-1:0] y_data,
   output logic                  loaded,
   output logic                  busy
);
   localparam int LAT = 2 * SIZE;
   localparam int RW  = $clog2(SIZE);
   localparam int CW  = $clog2(2 * SIZE + 1);

   typedef enum logic [1:0] {IDLE, LOAD, READY, DRAIN} state_t;

   state_t                               state_q, state_d;
   logic [RW-1:0]                        row_q, row_d;
   logic                                 loaded_q, loaded_d;
   logic [CW-1:0]                        cnt_q, cnt_d;
   logic [SIZE-1:0][SIZE-1:0][DW-1:0]    w_q, w_d;
   logic [LAT:0]                         vld_pipe_q, vld_pipe_d;
   logic [SIZE-1:0][ACC_W-1:0]           y_q, y_d;

   logic                                 x_fire;
   logic [SIZE-1:0][DW-1:0]              xm;
   logic [SIZE-1:0][SIZE-1:0][DW-1:0]    x_h;
   logic [SIZE-1:0][SIZE-1:0][ACC_W-1:0] ps_h;
   logic [SIZE-1:0][ACC_W-1:0]           dsk;

   assign w_ready = (state_q == LOAD);
   assign x_ready = (state_q == READY);
   assign x_fire  = x_valid & x_ready;
   assign y_valid = vld_pipe_q[LAT];
   assign y_data  = y_q;
   assign loaded  = loaded_q;
   assign busy    = (state_q == LOAD) | (state_q == DRAIN) | (cnt_q != '0);

   always_comb begin
      state_d  = state_q;
      row_d    = row_q;
      loaded_d = loaded_q;
      w_d      = w_q;
      case (state_q)
         IDLE: if (w_start) begin
            state_d  = LOAD;
            row_d    = '0;
            loaded_d = 1'b0;
         end
         LOAD: if (w_valid) begin
            w_d[row_q] = w_data;
            if (row_q == RW'(SIZE - 1)) begin
               state_d  = READY;
               loaded_d = 1'b1;
            end else begin
               row_d = row_q + 1'b1;
            end
         end
         READY: if (w_start) state_d = DRAIN;
         DRAIN: if (cnt_q == '0) begin
            state_d  = LOAD;
            row_d    = '0;
            loaded_d = 1'b0;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      cnt_d      = cnt_q + CW'(x_fire) - CW'(y_valid);
      vld_pipe_d = {vld_pipe_q[LAT-1:0], x_fire};
      y_d        = vld_pipe_q[LAT-1] ? dsk : y_q;
      xm         = x_fire ? x_data : '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         row_q      <= '0;
         loaded_q   <= 1'b0;
         cnt_q      <= '0;
         w_q        <= '0;
         vld_pipe_q <= '0;
         y_q        <= '0;
      end else begin
         state_q    <= state_d;
         row_q      <= row_d;
         loaded_q   <= loaded_d;
         cnt_q      <= cnt_d;
         w_q        <= w_d;
         vld_pipe_q <= vld_pipe_d;
         y_q        <= y_d;
      end
   end

   // Row r enters r cycles late; x then moves one column per cycle, psums one row per cycle.
   for (genvar r = 0; r < SIZE; r++) begin : g_row
      if (r == 0) begin : g_nosk
         assign x_h[0][0] = xm[0];
      end else begin : g_sk
         sa_ws_dly #(.W(DW), .D(r)) u_sk (.clk(clk), .rst(rst), .d(xm[r]), .q(x_h[r][0]));
      end
      for (genvar c = 0; c < SIZE; c++) begin : g_col
         if (c > 0) begin : g_xf
            sa_ws_dly #(.W(DW), .D(1)) u_xf (.clk(clk), .rst(rst), .d(x_h[r][c-1]), .q(x_h[r][c]));
         end
         if (r == 0) begin : g_top
            sa_ws_pe #(.DW(DW), .ACC_W(ACC_W)) u_pe (
               .clk(clk), .rst(rst), .w(w_q[r][c]), .x_in(x_h[r][c]),
               .psum_in('0), .psum_out(ps_h[r][c]));
         end else begin : g_mid
            sa_ws_pe #(.DW(DW), .ACC_W(ACC_W)) u_pe (
               .clk(clk), .rst(rst), .w(w_q[r][c]), .x_in(x_h[r][c]),
               .psum_in(ps_h[r-1][c]), .psum_out(ps_h[r][c]));
         end
      end
   end

   // Column c leaves the array c cycles late; pad so every lane lines up at the output register.
   for (genvar c = 0; c < SIZE; c++) begin : g_dsk
      sa_ws_dly #(.W(ACC_W), .D(SIZE - c)) u_dsk (
         .clk(clk), .rst(rst), .d(ps_h[SIZE-1][c]), .q(dsk[c]));
   end
endmodule

// File: tb/tb_sa_ws_stream.sv
// Directed bench for sa_ws_stream at SIZE=4, DW=8, ACC_W=12 (latency 8).
module tb_sa_ws_stream;
   localparam int SIZE = 4, DW = 8, ACC_W = 12, LAT = 2 * SIZE;

   logic        clk = 1'b0, rst = 1'b1;
   logic        w_start = 1'b0, w_valid = 1'b0, x_valid = 1'b0;
   logic [31:0] w_data = '0, x_data = '0;
   logic        w_ready, x_ready, y_valid, loaded, busy;
   logic [47:0] y_data;

   always #5 clk = ~clk;

   sa_ws_stream #(.SIZE(SIZE), .DW(DW), .ACC_W(ACC_W)) dut (
      .clk(clk), .rst(rst), .w_start(w_start), .w_valid(w_valid), .w_ready(w_ready),
      .w_data(w_data), .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data),
      .y_valid(y_valid), .y_data(y_data), .loaded(loaded), .busy(busy));

   typedef struct { int cyc; logic [47:0] y; } exp_t;
   exp_t exp_q[$];
   int n_chk = 0, n_fail = 0, cyc = 0, n_y = 0, wr_hi = 0, last_y = 0, wr_first = 0;
   logic [127:0] cur_w = '0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h @cyc %0d", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [11:0] ext(input logic [7:0] v);
`ifdef SA_SIGNED_EN
      return 12'($signed(v));
`else
      return 12'(v);
`endif
   endfunction

   function automatic logic [47:0] mm(input logic [31:0] x, input logic [127:0] w);
      logic [47:0] y = '0;
      for (int c = 0; c < SIZE; c++)
         for (int r = 0; r < SIZE; r++)
            y[c*12+:12] += ext(x[r*8+:8]) * ext(w[r*32+c*8+:8]);
      return y;
   endfunction

   always @(posedge clk) begin
      cyc = cyc + 1;
      #1;
      if (w_ready) wr_hi++;
      if (y_valid) begin
         n_y++;
         last_y = cyc;
         if (exp_q.size() == 0) chk("stray_y", 1, 0);
         else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("y_cyc", cyc, e.cyc);
            chk("y_data", y_data, e.y);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_x(input logic [31:0] v);
      x_valid = 1'b1;
      x_data  = v;
      if (x_ready) exp_q.push_back('{cyc + 1 + LAT, mm(v, cur_w)});
      step();
      x_valid = 1'b0;
   endtask

   task automatic wait_idle();
      for (int k = 0; k < 100 && busy; k++) step();
      chk("idle", busy, 0);
   endtask

   // hold_x: present an x beat together with w_start and keep it asserted through DRAIN/LOAD
   task automatic load_w(input logic [127:0] m, input logic hold_x, input logic [31:0] xv);
      w_start = 1'b1;
      if (hold_x) begin
         x_valid = 1'b1;
         x_data  = xv;
         if (x_ready) exp_q.push_back('{cyc + 1 + LAT, mm(xv, cur_w)});
      end
      step();
      w_start = 1'b0;
      cur_w   = m;
      if (hold_x) begin
         chk("drain_xready", x_ready, 0);
         chk("drain_busy", busy, 1);
      end
      for (int k = 0; k < 100 && !w_ready; k++) step();
      if (!w_ready) chk("w_ready_timeout", 0, 1);
      wr_first = cyc;
      for (int r = 0; r < SIZE; r++) begin
         w_valid = 1'b1;
         w_data  = m[r*32+:32];
         step();
      end
      w_valid = 1'b0;
      x_valid = 1'b0;
      chk("loaded", loaded, 1);
      chk("x_ready_after_load", x_ready, 1);
      chk("w_ready_after_load", w_ready, 0);
   endtask

   logic [31:0] xs [8] = '{32'h01020304, 32'h7F000001, 32'h00FF0010, 32'h11223344,
                           32'h80808080, 32'h0A0B0C0D, 32'h00000000, 32'hFFFFFFFF};
   localparam logic [127:0] W_ID  = 128'h01000000_00010000_00000100_00000001;
   localparam logic [127:0] W_FF  = {4{32'hFFFFFFFF}};
   localparam logic [127:0] W_2   = {4{32'h02020202}};
   localparam logic [127:0] W_SEQ = {32'h100F0E0D, 32'h0C0B0A09, 32'h08070605, 32'h04030201};
   localparam logic [127:0] W_1   = {4{32'h01010101}};

   initial begin
      int n_y0;
      repeat (3) step();
      chk("rst_y_valid", y_valid, 0);
      chk("rst_loaded", loaded, 0);
      chk("rst_busy", busy, 0);
      chk("rst_w_ready", w_ready, 0);
      chk("rst_x_ready", x_ready, 0);
      chk("rst_y_data", y_data, 0);
      rst = 1'b0;
      step();

      x_valid = 1'b1;
      x_data  = 32'h01010101;
      repeat (3) step();
      chk("idle_x_ready", x_ready, 0);
      x_valid = 1'b0;

      // identity weights, exact latency, hold after pulse
      wr_hi = 0;
      load_w(W_ID, 1'b0, '0);
      repeat (2) step();
      chk("t1_wready_beats", wr_hi, 4);
      send_x(32'h04030201);
      repeat (LAT - 1) step();
      chk("t1_no_early", y_valid, 0);
      step();
      chk("t1_yvalid", y_valid, 1);
      chk("t1_y", y_data, 48'h004003002001);
      step();
      chk("t1_pulse", y_valid, 0);
      chk("t1_hold", y_data, 48'h004003002001);
      wait_idle();

      // full-scale operands
      load_w(W_FF, 1'b0, '0);
      send_x(32'hFFFFFFFF);
      repeat (LAT) step();
`ifdef SA_SIGNED_EN
      chk("t2_y", y_data, 48'h004004004004);
`else
      chk("t2_y_wrap", y_data, 48'h804804804804);
`endif
      wait_idle();

      // signedness of 8'hFF
      load_w(W_2, 1'b0, '0);
      send_x(32'hFFFFFFFF);
      repeat (LAT) step();
`ifdef SA_SIGNED_EN
      chk("t3_y_signed", y_data, 48'hFF8FF8FF8FF8);
`else
      chk("t3_y_unsigned", y_data, 48'h7F87F87F87F8);
`endif
      wait_idle();

      // streaming with a 2-cycle bubble after the 3rd vector
      load_w(W_SEQ, 1'b0, '0);
      n_y0 = n_y;
      for (int i = 0; i < 8; i++) begin
         send_x(xs[i]);
         if (i == 2) repeat (2) step();
      end
      wait_idle();
      chk("t4_count", n_y - n_y0, 8);

      // reload while 3 vectors are in flight (3rd accepted with w_start)
      send_x(32'h01020304);
      send_x(32'h05060708);
      load_w(W_1, 1'b1, 32'h090A0B0C);
      chk("t5_drain_wait", wr_first > last_y, 1);
      send_x(32'h01020304);
      repeat (LAT) step();
      chk("t5_new_w", y_data, 48'h00A00A00A00A);
      wait_idle();

      // reset 3 cycles after an accept
      send_x(32'h01010101);
      repeat (3) step();
      rst = 1'b1;
      #1;
      chk("t6_y_valid", y_valid, 0);
      chk("t6_loaded", loaded, 0);
      chk("t6_busy", busy, 0);
      exp_q.delete();
      repeat (2) step();
      rst = 1'b0;
      x_valid = 1'b1;
      x_data  = 32'h02020202;
      repeat (12) step();
      chk("t6_x_ready", x_ready, 0);
      chk("t6_loaded_after", loaded, 0);
      x_valid = 1'b0;
      load_w(W_SEQ, 1'b0, '0);
      send_x(32'h0A0B0C0D);
      wait_idle();

      repeat (3) step();
      chk("exp_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1);
   end
endmodule
